// File: rtl/matrix_bus_master.sv
// Bus initiator that loads A/B operands into the matrix multiplier slave, starts it, and reads results back.
// Optional macro WAIT_TIMEOUT_EN adds an interrupt-wait watchdog of TIMEOUT cycles.
module matrix_bus_master #(
  parameter int N_WORDS  = 8,
  parameter int READ_LAT = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        op_valid,
  input  logic [31:0] op_data,
  output logic        op_ready,
  output logic        M_req,
  input  logic        M_grant,
  output logic        M_sel,
  output logic        M_wr,
  output logic [7:0]  M_address,
  output logic [31:0] M_dout,
  input  logic [31:0] M_din,
  input  logic        m_interrupt,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [2:0]  res_addr,
  input  logic        res_ready,
  output logic        busy,
  output logic        done,
  output logic        aborted
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD_A    = 4'd1;
  localparam logic [3:0] S_LOAD_B    = 4'd2;
  localparam logic [3:0] S_CFG_IE    = 4'd3;
  localparam logic [3:0] S_START_MUL = 4'd4;
  localparam logic [3:0] S_START_ADD = 4'd5;
  localparam logic [3:0] S_WAIT_INT  = 4'd6;
  localparam logic [3:0] S_SET_RADDR = 4'd7;
  localparam logic [3:0] S_READ_WAIT = 4'd8;
  localparam logic [3:0] S_PUSH      = 4'd9;
  localparam logic [3:0] S_CLR1      = 4'd10;
  localparam logic [3:0] S_CLR0      = 4'd11;

  localparam logic [7:0] REG_A        = 8'h00;
  localparam logic [7:0] REG_B        = 8'h01;
  localparam logic [7:0] REG_IE       = 8'h02;
  localparam logic [7:0] REG_MUL      = 8'h03;
  localparam logic [7:0] REG_ADD      = 8'h04;
  localparam logic [7:0] REG_OP_CLEAR = 8'h05;
  localparam logic [7:0] REG_RADDR    = 8'h06;

  localparam logic [2:0]    LAST     = 3'(N_WORDS - 1);
  localparam int            LW       = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(READ_LAT - 1);

  logic [3:0]    state_reg, state_next;
  logic [2:0]    cnt_reg, cnt_next;
  logic [LW-1:0] lat_reg, lat_next;
  logic          abort_flag_reg, abort_flag_next;
  logic          res_valid_reg, res_valid_next;
  logic [31:0]   res_data_reg, res_data_next;
  logic [2:0]    res_addr_reg, res_addr_next;
  logic          done_reg, done_next;
  logic          aborted_reg, aborted_next;

  logic          bus_wr;
  logic [7:0]    bus_addr;
  logic [31:0]   bus_data;
  logic          op_ready_c;
  logic          abortable;

`ifdef WAIT_TIMEOUT_EN
  logic [15:0]   tmo_reg;

  // Free-running only while waiting, so it restarts from zero on every WAIT_INT entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_reg <= 16'd0;
    end else if (state_reg != S_WAIT_INT) begin
      tmo_reg <= 16'd0;
    end else begin
      tmo_reg <= tmo_reg + 16'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  assign abortable = (state_reg >= S_LOAD_A) && (state_reg <= S_PUSH);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    lat_next        = lat_reg;
    abort_flag_next = abort_flag_reg;
    res_valid_next  = res_valid_reg;
    res_data_next   = res_data_reg;
    res_addr_next   = res_addr_reg;
    done_next       = 1'b0;
    aborted_next    = 1'b0;
    bus_wr          = 1'b0;
    bus_addr        = 8'h00;
    bus_data        = 32'h0;
    op_ready_c      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next      = S_LOAD_A;
          cnt_next        = 3'd0;
          abort_flag_next = 1'b0;
        end
      end
      S_LOAD_A, S_LOAD_B: begin
        // Accepting an operand and writing it are the same cycle, so ready follows grant.
        bus_addr   = (state_reg == S_LOAD_A) ? REG_A : REG_B;
        bus_data   = op_data;
        op_ready_c = M_grant;
        if (op_valid && M_grant) begin
          bus_wr = 1'b1;
          if (cnt_reg == LAST) begin
            cnt_next   = 3'd0;
            state_next = (state_reg == S_LOAD_A) ? S_LOAD_B : S_CFG_IE;
          end else begin
            cnt_next = cnt_reg + 3'd1;
          end
        end
      end
      S_CFG_IE: begin
        bus_addr = REG_IE;
        bus_data = 32'd1;
        if (M_grant) begin
          bus_wr     = 1'b1;
          state_next = S_START_MUL;
        end
      end
      S_START_MUL: begin
        bus_addr = REG_MUL;
        bus_data = 32'd1;
        if (M_grant) begin
          bus_wr     = 1'b1;
          state_next = S_START_ADD;
        end
      end
      S_START_ADD: begin
        bus_addr = REG_ADD;
        bus_data = 32'd1;
        if (M_grant) begin
          bus_wr     = 1'b1;
          state_next = S_WAIT_INT;
        end
      end
      S_WAIT_INT: begin
        if (m_interrupt) begin
          state_next = S_SET_RADDR;
          cnt_next   = 3'd0;
        end
`ifdef WAIT_TIMEOUT_EN
        else if (tmo_reg == 16'(TIMEOUT - 1)) begin
          state_next      = S_CLR1;
          abort_flag_next = 1'b1;
        end
`endif
      end
      S_SET_RADDR: begin
        bus_addr = REG_RADDR;
        bus_data = {29'd0, cnt_reg};
        if (M_grant) begin
          bus_wr     = 1'b1;
          lat_next   = '0;
          state_next = S_READ_WAIT;
        end
      end
      S_READ_WAIT: begin
        if (lat_reg == LAT_LAST) begin
          res_valid_next = 1'b1;
          res_data_next  = M_din;
          res_addr_next  = cnt_reg;
          state_next     = S_PUSH;
        end else begin
          lat_next = lat_reg + LW'(1);
        end
      end
      S_PUSH: begin
        if (res_ready) begin
          res_valid_next = 1'b0;
          if (cnt_reg == LAST) begin
            state_next = S_CLR1;
          end else begin
            cnt_next   = cnt_reg + 3'd1;
            state_next = S_SET_RADDR;
          end
        end
      end
      S_CLR1: begin
        bus_addr = REG_OP_CLEAR;
        bus_data = 32'd1;
        if (M_grant) begin
          bus_wr     = 1'b1;
          state_next = S_CLR0;
        end
      end
      S_CLR0: begin
        bus_addr = REG_OP_CLEAR;
        bus_data = 32'd0;
        if (M_grant) begin
          bus_wr       = 1'b1;
          state_next   = S_IDLE;
          done_next    = !abort_flag_reg;
          aborted_next = abort_flag_reg;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // Abort lets this cycle's bus write finish, then forces the clear sequence.
    if (abort && abortable) begin
      state_next      = S_CLR1;
      abort_flag_next = 1'b1;
      res_valid_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= 3'd0;
      lat_reg        <= '0;
      abort_flag_reg <= 1'b0;
      res_valid_reg  <= 1'b0;
      res_data_reg   <= 32'h0;
      res_addr_reg   <= 3'd0;
      done_reg       <= 1'b0;
      aborted_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      lat_reg        <= lat_next;
      abort_flag_reg <= abort_flag_next;
      res_valid_reg  <= res_valid_next;
      res_data_reg   <= res_data_next;
      res_addr_reg   <= res_addr_next;
      done_reg       <= done_next;
      aborted_reg    <= aborted_next;
    end
  end

  assign busy      = (state_reg != S_IDLE);
  assign M_req     = busy;
  assign op_ready  = op_ready_c;
  assign M_sel     = bus_wr;
  assign M_wr      = bus_wr;
  assign M_address = bus_addr;
  assign M_dout    = bus_data;
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_addr  = res_addr_reg;
  assign done      = done_reg;
  assign aborted   = aborted_reg;

endmodule

// File: tb/tb_matrix_bus_master.sv
// Directed bench for matrix_bus_master: cycle vector table plus full-job sequences against a slave model.
module tb_matrix_bus_master;
  localparam int N   = 8;
  localparam int RL  = 2;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, op_valid = 1'b0;
  logic [31:0] op_data = 32'h0;
  logic        op_ready, M_req, M_sel, M_wr;
  logic        M_grant = 1'b1;
  logic [7:0]  M_address;
  logic [31:0] M_dout;
  logic [31:0] M_din = 32'hDEAD_BEEF;
  logic        m_interrupt = 1'b0;
  logic        res_valid;
  logic [31:0] res_data;
  logic [2:0]  res_addr;
  logic        res_ready = 1'b1;
  logic        busy, done, aborted;

  matrix_bus_master #(.N_WORDS(N), .READ_LAT(RL), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
    .M_req(M_req), .M_grant(M_grant), .M_sel(M_sel), .M_wr(M_wr),
    .M_address(M_address), .M_dout(M_dout), .M_din(M_din),
    .m_interrupt(m_interrupt), .res_valid(res_valid), .res_data(res_data),
    .res_addr(res_addr), .res_ready(res_ready), .busy(busy), .done(done),
    .aborted(aborted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct { logic wr; logic [7:0] addr; logic [31:0] data; int c; } bus_ent_t;
  typedef struct { logic [2:0] addr; logic [31:0] data; } res_ent_t;
  bus_ent_t bus_q[$];
  res_ent_t res_q[$];
  int done_cnt = 0, aborted_cnt = 0, res_seen = 0, bad_sel = 0;
  logic       v1 = 1'b0, v2 = 1'b0;
  logic [2:0] a1 = 3'd0, a2 = 3'd0;

  // Bus/result monitor and slave read port: data for a READ_ADDRESS write at cycle t is valid only in cycle t+2.
  always @(negedge clk) begin
    if (M_sel) begin
      bus_q.push_back(bus_ent_t'{M_wr, M_address, M_dout, cyc});
      $display("bus write addr=%02h data=%08h cycle=%0d", M_address, M_dout, cyc);
      if (!M_grant) bad_sel <= bad_sel + 1;
    end
    if (res_valid) res_seen <= res_seen + 1;
    if (res_valid && res_ready) begin
      res_q.push_back(res_ent_t'{res_addr, res_data});
      $display("result addr=%0d data=%08h", res_addr, res_data);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (aborted) aborted_cnt <= aborted_cnt + 1;
    M_din <= v2 ? 32'(a2) * 32'd3 : 32'hDEAD_BEEF;
    v2 <= v1;
    a2 <= a1;
    v1 <= M_sel && M_wr && (M_address == 8'h06);
    a1 <= M_dout[2:0];
  end

  typedef struct {
    logic start, abort, grant, op_valid;
    logic [31:0] op_data;
    logic busy, op_ready, sel;
    logic [7:0] addr;
    logic [31:0] dout;
    logic done, aborted;
  } cyc_vec_t;
  typedef struct { logic [7:0] addr; logic [31:0] data; } wr_vec_t;

  cyc_vec_t tv[12];
  wr_vec_t  exp_wr[29];
  int bus_base, res_base, done_base, abt_base, seen_base, bad_base;

  task automatic run_job(input bit toggle, input bit gaps, input int stall_word,
                         input int imode, input int rst_at);
    int op_idx = 0;
    int stall_n = 0;
    int t_add = -1;
    bit saw_add = 0;
    bit fin = 0;
    bus_base  = bus_q.size();
    res_base  = res_q.size();
    done_base = done_cnt;
    abt_base  = aborted_cnt;
    seen_base = res_seen;
    bad_base  = bad_sel;
    for (int k = 0; k < 2000 && !fin; k++) begin
      @(posedge clk); #1;
      start       = (k == 0);
      abort       = 1'b0;
      M_grant     = toggle ? (k % 2 == 1) : 1'b1;
      op_valid    = (op_idx < 2 * N) && !(gaps && op_idx < N && (k % 3 == 0));
      op_data     = (op_idx < N) ? 32'(op_idx + 1) : 32'(16 + op_idx - N);
      m_interrupt = (imode == 0) && saw_add;
      if (imode == 1 && saw_add && k == t_add + 3) abort = 1'b1;
`ifndef WAIT_TIMEOUT_EN
      if (imode == 2 && saw_add && k == t_add + 101) begin
        chk("wait_int_still_busy", busy, 1);
        chk("wait_int_no_bus", bus_q.size() - bus_base, 19);
        abort = 1'b1;
      end
`endif
      res_ready = 1'b1;
      if (stall_word >= 0 && res_valid && res_addr == 3'(stall_word) && stall_n < 5) begin
        res_ready = 1'b0;
        stall_n++;
      end
      if (rst_at >= 0 && op_idx == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk("reset_mid_job_ctrl", {op_ready, M_req, M_sel, M_wr, busy, done, aborted,
                                   res_valid, res_addr, M_address}, 0);
        chk("reset_mid_job_data", {M_dout, res_data}, 0);
        start = 1'b0;
        op_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        fin = 1;
      end
      if (!fin) begin
        @(negedge clk);
        if (op_valid && op_ready) op_idx++;
        if (M_sel && M_address == 8'h04) begin
          saw_add = 1;
          t_add = k;
        end
        if (!res_ready) begin
          chk("stall_res_data", res_data, 32'(stall_word * 3));
          chk("stall_res_addr", res_addr, 3'(stall_word));
          chk("stall_no_bus", M_sel, 0);
        end
        if (done) chk("done_with_busy_low", busy, 0);
        if (done || aborted) fin = 1;
      end
    end
    if (!fin) begin
      n_vec++;
      n_err++;
      $display("FAIL job_budget: job did not end, got busy=%0b, required done or aborted", busy);
    end
    if (stall_word >= 0) chk("stall_cycles", stall_n, 5);
    start = 1'b0; abort = 1'b0; op_valid = 1'b0; m_interrupt = 1'b0;
    res_ready = 1'b1; M_grant = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_prefix(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      if (bus_base + i < bus_q.size()) begin
        chk($sformatf("%s_bus[%0d]", name, i),
            {bus_q[bus_base + i].wr, bus_q[bus_base + i].addr, bus_q[bus_base + i].data},
            {1'b1, exp_wr[i].addr, exp_wr[i].data});
      end
    end
  endtask

  task automatic check_normal(input string name);
    chk({name, "_bus_count"}, bus_q.size() - bus_base, 29);
    check_prefix(name, 29);
    chk({name, "_res_count"}, res_q.size() - res_base, N);
    for (int i = 0; i < N; i++) begin
      if (res_base + i < res_q.size()) begin
        chk($sformatf("%s_res[%0d]", name, i),
            {res_q[res_base + i].addr, res_q[res_base + i].data}, {3'(i), 32'(i * 3)});
      end
    end
    chk({name, "_done"}, done_cnt - done_base, 1);
    chk({name, "_aborted"}, aborted_cnt - abt_base, 0);
    chk({name, "_sel_no_grant"}, bad_sel - bad_base, 0);
  endtask

  task automatic check_aborted(input string name);
    int n = bus_q.size() - bus_base;
    chk({name, "_bus_count"}, n, 21);
    check_prefix(name, 19);
    if (n >= 2) begin
      chk({name, "_clr1"}, {bus_q[bus_q.size() - 2].addr, bus_q[bus_q.size() - 2].data}, {8'h05, 32'd1});
      chk({name, "_clr0"}, {bus_q[bus_q.size() - 1].addr, bus_q[bus_q.size() - 1].data}, {8'h05, 32'd0});
    end
    chk({name, "_aborted"}, aborted_cnt - abt_base, 1);
    chk({name, "_done"}, done_cnt - done_base, 0);
    chk({name, "_res_valid"}, res_seen - seen_base, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1);
  end

  initial begin
    //            start abort grant opv  op_data        busy rdy sel addr   dout    done abt
    tv[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h00, 32'h0,  1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h00, 32'h0,  1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA0001, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0,  1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h00, 32'h0,  1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h11,       1'b1, 1'b1, 1'b1, 8'h00, 32'h11, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h22,       1'b1, 1'b1, 1'b1, 8'h00, 32'h22, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h33,       1'b1, 1'b1, 1'b1, 8'h00, 32'h33, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 32'h0,  1'b0, 1'b0};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h05, 32'h1,  1'b0, 1'b0};
    tv[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h05, 32'h0,  1'b0, 1'b0};
    tv[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h00, 32'h0,  1'b0, 1'b1};
    tv[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h00, 32'h0,  1'b0, 1'b0};

    for (int i = 0; i < N; i++) begin
      exp_wr[i]      = '{8'h00, 32'(i + 1)};
      exp_wr[N + i]  = '{8'h01, 32'(16 + i)};
      exp_wr[19 + i] = '{8'h06, 32'(i)};
    end
    exp_wr[16] = '{8'h02, 32'd1};
    exp_wr[17] = '{8'h03, 32'd1};
    exp_wr[18] = '{8'h04, 32'd1};
    exp_wr[27] = '{8'h05, 32'd1};
    exp_wr[28] = '{8'h05, 32'd0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {op_ready, M_req, M_sel, M_wr, busy, done, aborted, res_valid,
                       res_addr, M_address}, 0);
    chk("reset_data", {M_dout, res_data}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      start    = tv[i].start;
      abort    = tv[i].abort;
      M_grant  = tv[i].grant;
      op_valid = tv[i].op_valid;
      op_data  = tv[i].op_data;
      @(negedge clk);
      chk($sformatf("vec%0d_ctrl", i), {busy, M_req, op_ready, M_sel, M_wr, done, aborted},
          {tv[i].busy, tv[i].busy, tv[i].op_ready, tv[i].sel, tv[i].sel, tv[i].done, tv[i].aborted});
      if (tv[i].sel) chk($sformatf("vec%0d_bus", i), {M_address, M_dout}, {tv[i].addr, tv[i].dout});
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; op_valid = 1'b0; M_grant = 1'b1;

    run_job(1'b0, 1'b0, -1, 0, -1);
    check_normal("normal");
    run_job(1'b1, 1'b1, -1, 0, -1);
    check_normal("grant_toggle");
    run_job(1'b0, 1'b0, 3, 0, -1);
    check_normal("res_stall");
    run_job(1'b0, 1'b0, -1, 1, -1);
    check_aborted("abort_wait");
    run_job(1'b0, 1'b0, -1, 0, 10);
    run_job(1'b0, 1'b0, -1, 0, -1);
    check_normal("after_reset");
    run_job(1'b0, 1'b0, -1, 2, -1);
    check_aborted("no_interrupt");
`ifdef WAIT_TIMEOUT_EN
    if (bus_q.size() - bus_base >= 20)
      chk("timeout_latency", bus_q[bus_base + 19].c - bus_q[bus_base + 18].c, TMO + 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_bus_master.md
Name: matrix_bus_master

Overview:
- Bus initiator for the matrix multiplier's memory-mapped slave register block.
- Takes A/B operand words from an upstream stream and writes them to the slave.
- Programs interrupt-enable and start registers, waits for the slave interrupt, then reads back each result word through the READ_ADDRESS window.
- Streams results downstream and finishes with an operation-clear sequence, leaving the slave in its IDLE state.

Parameters:
- N_WORDS, 8, words per matrix and number of result words; legal range 1..8 (3-bit read address).
- READ_LAT, 2, cycles from the READ_ADDRESS write to valid read data on M_din.
- TIMEOUT, 1024, interrupt wait limit in cycles; used only with WAIT_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a job; ignored unless in IDLE.
- abort  input  1  one-cycle pulse that cancels the job in progress.
- op_valid  input  1  operand word available.
- op_data  input  32  operand word: N_WORDS A words first, then N_WORDS B words.
- op_ready  output  1  operand word accepted this cycle.
- M_req  output  1  bus request, held high from job start until return to IDLE.
- M_grant  input  1  bus granted; a bus cycle is issued only while high.
- M_sel  output  1  slave select, one-cycle pulse per bus cycle.
- M_wr  output  1  write strobe, qualified by M_sel.
- M_address  output  8  register offset.
- M_dout  output  32  write data (feeds the slave's data inputs).
- M_din  input  32  read data from the slave.
- m_interrupt  input  1  slave completion interrupt.
- res_valid  output  1  result word valid.
- res_data  output  32  result word.
- res_addr  output  3  result index.
- res_ready  input  1  downstream accepts the result.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  one-cycle pulse when abort or timeout completes its clear.

Behaviour:
- Reset values: all outputs 0; M_address 0; state IDLE; internal counters 0.
- Register offsets: A=0x00, B=0x01, IE=0x02, MULTI_START=0x03, ADD_START=0x04, OP_CLEAR=0x05, READ_ADDRESS=0x06.
- Bus write: one cycle with M_sel=1, M_wr=1, and M_address/M_dout valid. It issues only in a cycle with M_grant=1. If grant is low, the FSM holds and M_sel stays 0.
- States and transitions:
  - IDLE: start -> LOAD_A.
  - LOAD_A: op_ready = M_grant. Each op_valid&op_ready writes op_data to 0x00 and increments cnt. cnt==N_WORDS-1 on accept -> LOAD_B with cnt cleared.
  - LOAD_B: same handshake, writes to 0x01 -> CFG_IE.
  - CFG_IE: write 1 to 0x02 -> START_MUL.
  - START_MUL: write 1 to 0x03 -> START_ADD.
  - START_ADD: write 1 to 0x04 -> WAIT_INT.
  - WAIT_INT: m_interrupt high -> SET_RADDR with cnt=0.
  - SET_RADDR: write cnt to 0x06 -> READ_WAIT.
  - READ_WAIT: counts READ_LAT cycles with M_sel=0, then captures M_din into res_data with res_addr=cnt and raises res_valid -> PUSH.
  - PUSH: hold res_valid/res_data until res_ready. On the handshake, cnt==N_WORDS-1 -> CLR1, else cnt+1 -> SET_RADDR.
  - CLR1: write 1 to 0x05 -> CLR0.
  - CLR0: write 0 to 0x05 -> IDLE, pulsing done (or aborted if the clear was abort-initiated).
- Operand handshake: op_ready is high only in LOAD_A/LOAD_B with M_grant=1. Accept and bus write happen in the same cycle, so an operand is never accepted without being written.
- Abort in LOAD_A..PUSH: the current cycle's bus write, if any, completes; the next state is CLR1. res_valid drops. An abort-flag is set so CLR0 pulses aborted, not done. abort in IDLE/CLR1/CLR0 is ignored.
- start while busy is ignored. start and abort in the same cycle in IDLE: the job starts and abort is ignored.
- m_interrupt outside WAIT_INT is ignored.
- reset_n low mid-job: immediate return to IDLE with all outputs 0. No clear sequence is issued; the slave is reset by the same reset.

Optional Feature:
- Macro WAIT_TIMEOUT_EN.
- Defined: a 16-bit counter runs in WAIT_INT and clears on entry. Reaching TIMEOUT without m_interrupt -> CLR1 with the abort-flag set, so the job ends with an aborted pulse. Interrupt and timeout in the same cycle: interrupt wins.
- Undefined: WAIT_INT waits indefinitely; no counter is present.

Test Plan:
- Normal job, N_WORDS=8, grant tied high, A=1..8, B=0x10..0x17, slave model returns result=rAddr*3: exactly 16 data writes, then 1 to 0x02/0x03/0x04; res_addr 0..7 with res_data 0,3,..21; writes 0x05=1 then 0x05=0; done pulses once; busy falls the same cycle.
- Grant toggling every other cycle, plus op_valid gaps in LOAD_A: no M_sel while grant=0; operand order preserved; 16 writes total.
- res_ready held low 5 cycles on word 3: res_data/res_addr stable throughout; no READ_ADDRESS write for word 4 until the handshake.
- abort in WAIT_INT: next bus cycles are 0x05=1 then 0x05=0; aborted pulses; done stays 0; res_valid never asserted.
- reset_n asserted during LOAD_B: all outputs 0 immediately; a later start runs a full normal job.
- WAIT_TIMEOUT_EN with TIMEOUT=20 and no interrupt: CLR1 entered 20 cycles after WAIT_INT entry; aborted pulses. Without the macro, the FSM is still in WAIT_INT after 100 cycles.
